// File: rtl/hack_boot_ctrl_if.sv
// Handshake and ROM-write bundle between the program source, the boot controller and the
// instruction ROM / CPU reset.
interface hack_boot_ctrl_if;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        reload;
    logic        rom_we;
    logic [14:0] rom_addr;
    logic [15:0] rom_din;
    logic        cpu_reset;
    logic [15:0] word_count;
    logic        running;
    logic        error;

    modport master (
        output in_data, in_valid, in_last, reload,
        input  in_ready, rom_we, rom_addr, rom_din, cpu_reset, word_count, running, error
    );

    modport slave (
        input  in_data, in_valid, in_last, reload,
        output in_ready, rom_we, rom_addr, rom_din, cpu_reset, word_count, running, error
    );
endinterface

// File: rtl/hack_boot_ctrl.sv
// Boot/program-load controller for the Hack computer: streams words into instruction ROM from
// address 0, keeps the CPU in reset while loading plus a settle period, then releases it.
module hack_boot_ctrl #(
    parameter int unsigned DEPTH       = 32768,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input logic             clock,
    input logic             reset,
    hack_boot_ctrl_if.slave bus
);

    localparam int unsigned HoldW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [14:0] LastAddr = 15'(DEPTH - 1);

    typedef enum logic [1:0] {StLoad, StHold, StRun, StError} state_e;

    state_e             state_q, state_d;
    logic [14:0]        addr_q, addr_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [15:0]        count_q, count_d;
    logic               rom_we_q, rom_we_d;
    logic [14:0]        rom_addr_q, rom_addr_d;
    logic [15:0]        rom_din_q, rom_din_d;
    logic               in_ready_q, in_ready_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic               running_q, running_d;
    logic               error_q, error_d;
    logic               accept;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StLoad;
            addr_q      <= '0;
            hold_q      <= '0;
            count_q     <= '0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_din_q   <= '0;
            in_ready_q  <= 1'b1;
            cpu_reset_q <= 1'b1;
            running_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            hold_q      <= hold_d;
            count_q     <= count_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_din_q   <= rom_din_d;
            in_ready_q  <= in_ready_d;
            cpu_reset_q <= cpu_reset_d;
            running_q   <= running_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        hold_d     = hold_q;
        count_d    = count_q;
        rom_we_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        rom_din_d  = rom_din_q;
        accept     = bus.in_valid & in_ready_q;

        unique case (state_q)
            StLoad: begin
                if (accept) begin
                    rom_we_d   = 1'b1;
                    rom_addr_d = addr_q;
                    rom_din_d  = bus.in_data;
                    addr_d     = addr_q + 15'd1;
                    count_d    = count_q + 16'd1;
                    if (bus.in_last) begin
                        state_d = StHold;
                        hold_d  = HoldW'(HOLD_CYCLES);
                    end else if (addr_q == LastAddr) begin
                        // ROM is full and the program has not ended: the word is still written.
                        state_d = StError;
                    end
                end
            end
            StHold: begin
                if (hold_q <= HoldW'(1)) begin
                    state_d = StRun;
                end else begin
                    hold_d = hold_q - HoldW'(1);
                end
            end
            StRun, StError: begin
                if (bus.reload) begin
                    state_d = StLoad;
                    addr_d  = '0;
                    count_d = '0;
                end
            end
            default: state_d = StLoad;
        endcase

        // Status outputs are registered copies of the state being entered.
        in_ready_d  = (state_d == StLoad);
        cpu_reset_d = (state_d != StRun);
        running_d   = (state_d == StRun);
        error_d     = (state_d == StError);
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.rom_we     = rom_we_q;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.rom_din    = rom_din_q;
    assign bus.cpu_reset  = cpu_reset_q;
    assign bus.word_count = count_q;
    assign bus.running    = running_q;
    assign bus.error      = error_q;

endmodule

// File: tb/tb_hack_boot_ctrl.sv
// Self-checking bench for hack_boot_ctrl: directed scenarios followed by randomized program
// loads, checked cycle by cycle against a transaction-level model and a bench-side ROM.
module tb_hack_boot_ctrl;
    localparam int Depth = 8;
    localparam int Hold  = 2;

    logic clock;
    logic reset;
    hack_boot_ctrl_if bus ();

    hack_boot_ctrl #(.DEPTH(Depth), .HOLD_CYCLES(Hold)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROM as the CPU would see it, captured from the write strobe.
    logic [15:0] rom [Depth] = '{default: 16'h0};
    always @(posedge clock) if (bus.rom_we) rom[bus.rom_addr[2:0]] <= bus.rom_din;

    int checks   = 0;
    int failures = 0;

    // Model: what the controller should be doing, in spec terms.
    logic [15:0] mrom [Depth] = '{default: 16'h0};
    bit          m_load, m_run, m_err, m_we;
    int          m_addr, m_count, m_hold;
    logic [15:0] m_wdata;
    int          m_waddr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit v, input bit l, input logic [15:0] d, input bit rl,
                              input bit rs);
        m_we = 1'b0;
        if (rs) begin
            m_load = 1; m_run = 0; m_err = 0; m_addr = 0; m_count = 0; m_hold = 0;
        end else if (m_load) begin
            if (v) begin
                m_we = 1; m_waddr = m_addr; m_wdata = d; mrom[m_addr] = d;
                m_addr++; m_count++;
                if (l) begin
                    m_load = 0; m_hold = Hold;
                end else if (m_addr == Depth) begin
                    m_load = 0; m_err = 1;
                end
            end
        end else if (m_run || m_err) begin
            if (rl) begin
                m_load = 1; m_run = 0; m_err = 0; m_addr = 0; m_count = 0;
            end
        end else begin
            m_hold--;
            if (m_hold == 0) m_run = 1;
        end
    endtask

    task automatic step(input bit v, input bit l, input logic [15:0] d, input bit rl, input bit rs);
        bus.in_valid = v; bus.in_last = l; bus.in_data = d; bus.reload = rl; reset = rs;
        @(posedge clock);
        #1;
        model_edge(v, l, d, rl, rs);
        chk("in_ready", bus.in_ready, m_load);
        chk("cpu_reset", bus.cpu_reset, !m_run);
        chk("running", bus.running, m_run);
        chk("error", bus.error, m_err);
        chk("word_count", bus.word_count, m_count);
        chk("rom_we", bus.rom_we, m_we);
        if (m_we) begin
            chk("rom_addr", bus.rom_addr, m_waddr);
            chk("rom_din", bus.rom_din, m_wdata);
        end
        if (rs) begin
            chk("rst_rom_addr", bus.rom_addr, 0);
            chk("rst_rom_din", bus.rom_din, 0);
        end
        bus.in_valid = 0; bus.in_last = 0; bus.reload = 0; reset = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0, 0, 0);
    endtask

    task automatic rom_compare();
        for (int i = 0; i < Depth; i++) chk($sformatf("rom[%0d]", i), rom[i], mrom[i]);
    endtask

    initial begin
        int sent, len, cyc;
        bit v, l;
        bus.in_valid = 0; bus.in_last = 0; bus.in_data = 0; bus.reload = 0; reset = 1;

        // Reset, with reload asserted to show reset dominates.
        step(0, 0, 16'h0, 1, 1);
        step(0, 0, 16'h0, 0, 1);

        // Back-to-back three-word program.
        step(1, 0, 16'h0002, 0, 0);
        step(1, 0, 16'hEC10, 0, 0);
        step(1, 1, 16'h0003, 0, 0);
        chk("b2b_count", bus.word_count, 3);
        idle(1);
        chk("b2b_hold_reset", bus.cpu_reset, 1);
        idle(1);
        chk("b2b_released", bus.cpu_reset, 0);
        chk("b2b_running", bus.running, 1);
        rom_compare();

        // Same program with valid gaps; stray in_last without valid.
        step(0, 0, 16'h0, 1, 0);
        step(1, 0, 16'h0002, 0, 0);
        step(0, 1, 16'hFFFF, 0, 0);
        step(0, 0, 16'h0, 0, 0);
        step(1, 0, 16'hEC10, 0, 0);
        step(0, 0, 16'h0, 0, 0);
        step(1, 1, 16'h0003, 0, 0);
        idle(3);
        rom_compare();

        // Overflow, then a word while not ready.
        step(0, 0, 16'h0, 1, 0);
        for (int i = 0; i < Depth; i++) step(1, 0, 16'(16'h0100 + i), 0, 0);
        chk("ovf_error", bus.error, 1);
        chk("ovf_count", bus.word_count, Depth);
        step(1, 1, 16'hDEAD, 0, 0);
        idle(1);
        rom_compare();

        // Reload from ERROR, then from RUN.
        for (int k = 0; k < 2; k++) begin
            step(0, 0, 16'h0, 1, 0);
            chk("rl_cpu_reset", bus.cpu_reset, 1);
            step(1, 1, 16'h1234, 0, 0);
            idle(2);
            chk("rl_running", bus.running, 1);
        end

        // Mid-load reset, then reload during HOLD.
        step(0, 0, 16'h0, 1, 0);
        step(1, 0, 16'hAAAA, 0, 0);
        step(1, 0, 16'hBBBB, 0, 0);
        step(0, 0, 16'h0, 0, 1);
        step(1, 0, 16'hCCCC, 0, 0);
        step(1, 1, 16'hDDDD, 0, 0);
        step(0, 0, 16'h0, 1, 0);
        step(0, 0, 16'h0, 0, 0);
        chk("hold_reload_run", bus.running, 1);
        rom_compare();

        // Randomized programs with gaps, stray reloads and occasional resets.
        for (int p = 0; p < 25; p++) begin
            if (!m_load) step(0, 0, 16'h0, 1, 0);
            len  = $urandom_range(1, Depth + 1);
            sent = 0;
            cyc  = 0;
            while (m_load && cyc < 60) begin
                v = ($urandom_range(0, 2) != 0);
                l = (sent == len - 1);
                if (m_load && v) sent++;
                step(v, l, 16'($urandom()), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 40) == 0));
                cyc++;
            end
            chk("rand_progress", m_load, 0);
            idle(Hold + 1);
            rom_compare();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
